dram_bank_fsm: RTL and testbench

- Per-bank controller for the DDR2 controller.
- Consumes one bank request stream (valid/ready, id, ra, ca, len, wr) from the address decoder.
- Tracks bank state (closed/open row) and bank timing.
- Issues ACT/RD/WR/PRE/REF requests to the command scheduler over a req/gnt interface; one instance per DRAM bank.

---
 rtl/dram_bank_fsm_if.sv | 37 +++
 rtl/dram_bank_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_dram_bank_fsm.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_bank_fsm_if.sv
// Request-stream and scheduler req/gnt bundle for one DRAM bank controller.
// The bank FSM connects through the slave modport, its driver through master.
interface dram_bank_fsm_if #(
  parameter int BA_WIDTH = 2,
  parameter int RA_WIDTH = 14,
  parameter int CA_WIDTH = 10,
  parameter int ID_WIDTH = 4
);
  logic                req_valid;
  logic                req_ready;
  logic [ID_WIDTH-1:0] req_id;
  logic [RA_WIDTH-1:0] req_ra;
  logic [CA_WIDTH-1:0] req_ca;
  logic [3:0]          req_len;
  logic                req_wr;

  logic                act_req, rd_req, wr_req, pre_req, ref_req;
  logic                act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
  logic [BA_WIDTH-1:0] sched_ba;
  logic [RA_WIDTH-1:0] sched_ra;
  logic [CA_WIDTH-1:0] sched_ca;
  logic [ID_WIDTH-1:0] sched_id;

  modport master (
    output req_valid, req_id, req_ra, req_ca, req_len, req_wr,
    output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    input  req_ready, act_req, rd_req, wr_req, pre_req, ref_req,
    input  sched_ba, sched_ra, sched_ca, sched_id
  );

  modport slave (
    input  req_valid, req_id, req_ra, req_ca, req_len, req_wr,
    input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
    output req_ready, act_req, rd_req, wr_req, pre_req, ref_req,
    output sched_ba, sched_ra, sched_ca, sched_id
  );
endinterface

// File: rtl/dram_bank_fsm.sv
// Per-bank DDR2 controller: tracks the open row and bank timers, and turns
// bank requests into ACT/RD/WR/PRE/REF requests towards the command scheduler.
module dram_bank_fsm #(
  parameter int BANK_ID  = 0,
  parameter int BA_WIDTH = 2,
  parameter int RA_WIDTH = 14,
  parameter int CA_WIDTH = 10,
  parameter int ID_WIDTH = 4,
  parameter int TW       = 8,
  parameter int CA_INC   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dram_bank_fsm_if.slave bus,
  input  logic [TW-1:0] t_rcd_m1,
  input  logic [TW-1:0] t_rp_m1,
  input  logic [TW-1:0] t_ras_m1,
  input  logic [TW-1:0] t_rfc_m1,
  input  logic [TW-1:0] t_rtp_m1,
  input  logic [TW-1:0] t_wtp_m1,
  input  logic          ref_req_i,
  output logic          ref_done_o,
  output logic          row_open_o
);

  typedef enum logic [2:0] {
    IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING
  } state_t;

  state_t state_q, state_d;
  logic [TW-1:0] rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d;
  logic [TW-1:0] rfc_q, rfc_d, c2p_q, c2p_d;
  logic [3:0]    burst_q, burst_d;
  logic [RA_WIDTH-1:0] open_row_q, open_row_d;
  logic          row_open_q, row_open_d;
  logic          ref_done_q, ref_done_d;
  logic          act_q, act_d, rd_q, rd_d, wr_q, wr_d, pre_q, pre_d, ref_q, ref_d;
  logic [RA_WIDTH-1:0] sched_ra_q, sched_ra_d;
  logic [CA_WIDTH-1:0] sched_ca_q, sched_ca_d;
  logic [ID_WIDTH-1:0] sched_id_q, sched_id_d;

  logic act_g, rd_g, wr_g, pre_g, ref_g, col_g, final_col;
  logic hold_req, issue_col, hit, timers_clear;
  logic [CA_WIDTH-1:0] col_ca;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? v : v - TW'(1);
  endfunction

  assign act_g     = bus.act_gnt & act_q;
  assign rd_g      = bus.rd_gnt  & rd_q;
  assign wr_g      = bus.wr_gnt  & wr_q;
  assign pre_g     = bus.pre_gnt & pre_q;
  assign ref_g     = bus.ref_gnt & ref_q;
  assign col_g     = rd_g | wr_g;
  assign final_col = col_g && (burst_q == bus.req_len);
  assign hold_req  = (act_q & ~bus.act_gnt) | (rd_q & ~bus.rd_gnt) | (wr_q & ~bus.wr_gnt)
                   | (pre_q & ~bus.pre_gnt) | (ref_q & ~bus.ref_gnt);

  // Timers and bookkeeping as they will stand next cycle; request decisions
  // look at these so a registered request appears exactly when a timer hits 0.
  always_comb begin
    rcd_d      = act_g ? t_rcd_m1 : dec_sat(rcd_q);
    ras_d      = act_g ? t_ras_m1 : dec_sat(ras_q);
    rp_d       = pre_g ? t_rp_m1  : dec_sat(rp_q);
    rfc_d      = ref_g ? t_rfc_m1 : dec_sat(rfc_q);
    c2p_d      = rd_g ? t_rtp_m1 : (wr_g ? t_wtp_m1 : dec_sat(c2p_q));
    burst_d    = final_col ? 4'd0 : (col_g ? burst_q + 4'd1 : burst_q);
    open_row_d = act_g ? sched_ra_q : open_row_q;
    row_open_d = act_g ? 1'b1 : (pre_g ? 1'b0 : row_open_q);
    state_d    = state_q;
    ref_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_g) begin
          if (rfc_d == '0) ref_done_d = 1'b1;
          else             state_d    = REFRESHING;
        end else if (act_g) begin
          state_d = (rcd_d == '0) ? ACTIVE : ACTIVATING;
        end
      end
      ACTIVATING:  if (rcd_d == '0) state_d = ACTIVE;
      ACTIVE:      if (pre_g) state_d = (rp_d == '0) ? IDLE : PRECHARGING;
      PRECHARGING: if (rp_d == '0) state_d = IDLE;
      REFRESHING: begin
        if (rfc_d == '0) begin
          state_d    = IDLE;
          ref_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hit          = bus.req_valid && (bus.req_ra == open_row_d);
  assign timers_clear = (ras_d == '0) && (c2p_d == '0);
  assign col_ca       = bus.req_ca + CA_WIDTH'(burst_d) * CA_WIDTH'(CA_INC);

  // A pending request is frozen with its address until granted; otherwise the
  // next request is chosen fresh. The cycle after a final column grant is left
  // empty because the consumed request is still visible on the inputs.
  always_comb begin
    act_d      = act_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    pre_d      = pre_q;
    ref_d      = ref_q;
    sched_ra_d = sched_ra_q;
    sched_ca_d = sched_ca_q;
    sched_id_d = sched_id_q;
    issue_col  = 1'b0;
    if (!hold_req) begin
      act_d = 1'b0;
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      pre_d = 1'b0;
      ref_d = 1'b0;
      case (state_d)
        IDLE: begin
          if (ref_req_i) begin
            ref_d = 1'b1;
          end else if (bus.req_valid) begin
            act_d      = 1'b1;
            sched_ra_d = bus.req_ra;
            sched_id_d = bus.req_id;
          end
        end
        ACTIVE: begin
          if (burst_d != 4'd0) begin
            issue_col = 1'b1;
          end else if (!final_col) begin
            if (ref_req_i)                          pre_d     = timers_clear;
            else if (hit)                           issue_col = 1'b1;
            else if (bus.req_valid && timers_clear) pre_d     = 1'b1;
          end
        end
        default: ;
      endcase
      if (issue_col) begin
        rd_d       = ~bus.req_wr;
        wr_d       = bus.req_wr;
        sched_ca_d = col_ca;
        sched_id_d = bus.req_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rcd_q      <= '0;
      ras_q      <= '0;
      rp_q       <= '0;
      rfc_q      <= '0;
      c2p_q      <= '0;
      burst_q    <= '0;
      open_row_q <= '0;
      row_open_q <= 1'b0;
      ref_done_q <= 1'b0;
      act_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      pre_q      <= 1'b0;
      ref_q      <= 1'b0;
      sched_ra_q <= '0;
      sched_ca_q <= '0;
      sched_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rcd_q      <= rcd_d;
      ras_q      <= ras_d;
      rp_q       <= rp_d;
      rfc_q      <= rfc_d;
      c2p_q      <= c2p_d;
      burst_q    <= burst_d;
      open_row_q <= open_row_d;
      row_open_q <= row_open_d;
      ref_done_q <= ref_done_d;
      act_q      <= act_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pre_q      <= pre_d;
      ref_q      <= ref_d;
      sched_ra_q <= sched_ra_d;
      sched_ca_q <= sched_ca_d;
      sched_id_q <= sched_id_d;
    end
  end

  assign bus.req_ready = final_col;
  assign bus.act_req   = act_q;
  assign bus.rd_req    = rd_q;
  assign bus.wr_req    = wr_q;
  assign bus.pre_req   = pre_q;
  assign bus.ref_req   = ref_q;
  assign bus.sched_ba  = BA_WIDTH'(BANK_ID);
  assign bus.sched_ra  = sched_ra_q;
  assign bus.sched_ca  = sched_ca_q;
  assign bus.sched_id  = sched_id_q;
  assign ref_done_o    = ref_done_q;
  assign row_open_o    = row_open_q;

endmodule

// File: tb/tb_dram_bank_fsm.sv
// Directed bench for dram_bank_fsm: a grant-on-request scheduler model (which
// can be paused) answers the bank, and cycle distances are compared to hand values.
module tb_dram_bank_fsm;
  localparam int BA_W = 2;
  localparam int RA_W = 14;
  localparam int CA_W = 10;
  localparam int ID_W = 4;
  localparam int TW   = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_bank_fsm_if #(.BA_WIDTH(BA_W), .RA_WIDTH(RA_W), .CA_WIDTH(CA_W), .ID_WIDTH(ID_W)) bus ();

  logic [TW-1:0] tRcdM1, tRpM1, tRasM1, tRfcM1, tRtpM1, tWtpM1;
  logic refReq, refDone, rowOpen;
  logic gntEn, strayPre;
  int   errors = 0;
  int   checks = 0;

  // The scheduler grants any request in the cycle it is raised while gntEn is set.
  assign bus.act_gnt = gntEn & bus.act_req;
  assign bus.rd_gnt  = gntEn & bus.rd_req;
  assign bus.wr_gnt  = gntEn & bus.wr_req;
  assign bus.pre_gnt = (gntEn & bus.pre_req) | strayPre;
  assign bus.ref_gnt = gntEn & bus.ref_req;

  dram_bank_fsm #(
    .BANK_ID(2), .BA_WIDTH(BA_W), .RA_WIDTH(RA_W), .CA_WIDTH(CA_W),
    .ID_WIDTH(ID_W), .TW(TW), .CA_INC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .t_rcd_m1(tRcdM1), .t_rp_m1(tRpM1), .t_ras_m1(tRasM1),
    .t_rfc_m1(tRfcM1), .t_rtp_m1(tRtpM1), .t_wtp_m1(tWtpM1),
    .ref_req_i(refReq), .ref_done_o(refDone), .row_open_o(rowOpen)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [RA_W-1:0] ra,
                               input logic [CA_W-1:0] ca, input logic [3:0] len,
                               input logic wr, input logic [ID_W-1:0] id);
    bus.req_valid = valid;
    bus.req_ra    = ra;
    bus.req_ca    = ca;
    bus.req_len   = len;
    bus.req_wr    = wr;
    bus.req_id    = id;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic reqBit(input int sel);
    case (sel)
      0:       return bus.act_req;
      1:       return bus.rd_req;
      2:       return bus.wr_req;
      3:       return bus.pre_req;
      4:       return bus.ref_req;
      default: return refDone;
    endcase
  endfunction

  function automatic logic [31:0] anyReq();
    return {27'd0, bus.act_req, bus.rd_req, bus.wr_req, bus.pre_req, bus.ref_req};
  endfunction

  // Advances until the selected output is high, at most limit cycles.
  task automatic waitFor(input string tag, input int sel, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (reqBit(sel)) begin
        at = cyc;
        break;
      end
      tick();
    end
    checkOutput(tag, {31'd0, reqBit(sel)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, tAct, tPre, tRef, fin;
    logic [CA_W-1:0] expCa [4];
    expCa = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};

    rst_n = 1'b0;
    gntEn = 1'b1;
    strayPre = 1'b0;
    refReq = 1'b0;
    tRcdM1 = 8'd2; tRpM1 = 8'd1; tRasM1 = 8'd9;
    tRfcM1 = 8'd15; tRtpM1 = 8'd1; tWtpM1 = 8'd3;
    applyStimulus(1'b0, '0, '0, 4'd0, 1'b0, '0);

    $display("[TB] reset values");
    tick(); tick();
    checkOutput("rst_reqs", anyReq(), 32'd0);
    checkOutput("rst_ba", 32'(bus.sched_ba), 32'd2);
    checkOutput("rst_ra", 32'(bus.sched_ra), 32'd0);
    checkOutput("rst_ca_id", {16'(bus.sched_ca), 16'(bus.sched_id)}, 32'd0);
    checkOutput("rst_flags", {29'd0, bus.req_ready, refDone, rowOpen}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] read hit from IDLE with stray pre_gnt");
    applyStimulus(1'b1, 14'h55, 10'h010, 4'd0, 1'b0, 4'd3);
    strayPre = 1'b1;
    tick();
    strayPre = 1'b0;
    checkOutput("act_first", {31'd0, bus.act_req}, 32'd1);
    checkOutput("act_ra", 32'(bus.sched_ra), 32'h55);
    checkOutput("stray_pre", {31'd0, bus.pre_req}, 32'd0);
    tAct = cyc;
    tick();
    checkOutput("row_open_after_act", {31'd0, rowOpen}, 32'd1);
    waitFor("wait_rd1", 1, 10, t);
    checkOutput("rcd_delay", 32'(t - tAct), 32'd3);
    checkOutput("rd_ca", 32'(bus.sched_ca), 32'h010);
    checkOutput("rd_id", 32'(bus.sched_id), 32'd3);
    checkOutput("rd_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 14'h55, 10'h010, 4'd0, 1'b0, 4'd3);
    checkOutput("no_reissue", anyReq(), 32'd0);
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] write burst with column wrap");
    applyStimulus(1'b1, 14'h55, 10'h3F8, 4'd3, 1'b1, 4'd5);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput("wr_req", {31'd0, bus.wr_req}, 32'd1);
      checkOutput("wr_ca", 32'(bus.sched_ca), 32'(expCa[i]));
      checkOutput("wr_ready", {31'd0, bus.req_ready}, (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) tick();
    end
    fin = cyc;
    tick();
    tRcdM1 = 8'd1;
    applyStimulus(1'b1, 14'h66, 10'h020, 4'd0, 1'b0, 4'd6);
    checkOutput("wr_done", {31'd0, bus.wr_req}, 32'd0);

    $display("[TB] row miss after write and after fresh ACT");
    waitFor("wait_pre_wtp", 3, 20, t);
    checkOutput("wtp_delay", 32'(t - fin), 32'd4);
    tPre = t;
    tick();
    checkOutput("row_closed", {31'd0, rowOpen}, 32'd0);
    waitFor("wait_act_66", 0, 10, t);
    checkOutput("rp_delay1", 32'(t - tPre), 32'd2);
    checkOutput("act_ra_66", 32'(bus.sched_ra), 32'h66);
    tAct = t;
    waitFor("wait_rd_66", 1, 10, t);
    checkOutput("rcd_delay2", 32'(t - tAct), 32'd2);
    checkOutput("rd_ready_66", {31'd0, bus.req_ready}, 32'd1);
    tick();
    applyStimulus(1'b1, 14'h77, 10'h030, 4'd0, 1'b0, 4'd7);
    waitFor("wait_pre_ras", 3, 20, t);
    checkOutput("ras_delay", 32'(t - tAct), 32'd10);
    tPre = t;
    waitFor("wait_act_77", 0, 10, t);
    checkOutput("rp_delay2", 32'(t - tPre), 32'd2);
    checkOutput("act_ra_77", 32'(bus.sched_ra), 32'h77);
    tAct = t;
    waitFor("wait_rd_77", 1, 10, t);
    checkOutput("rd_ready_77", {31'd0, bus.req_ready}, 32'd1);

    $display("[TB] refresh while open with pending request");
    tick();
    applyStimulus(1'b1, 14'h88, 10'h050, 4'd0, 1'b0, 4'd8);
    refReq = 1'b1;
    waitFor("wait_pre_ref", 3, 20, t);
    checkOutput("ref_pre_delay", 32'(t - tAct), 32'd10);
    tPre = t;
    waitFor("wait_ref", 4, 10, t);
    checkOutput("ref_after_pre", 32'(t - tPre), 32'd2);
    checkOutput("ref_beats_act", {31'd0, bus.act_req}, 32'd0);
    refReq = 1'b0;
    tRef = t;
    tick();
    waitFor("wait_ref_done", 5, 30, t);
    checkOutput("rfc_delay", 32'(t - tRef), 32'd16);
    checkOutput("act_after_ref", {31'd0, bus.act_req}, 32'd1);
    checkOutput("act_ra_88", 32'(bus.sched_ra), 32'h88);
    tAct = t;
    tick();
    checkOutput("ref_done_pulse", {31'd0, refDone}, 32'd0);
    waitFor("wait_rd_88", 1, 10, t);
    checkOutput("rcd_delay3", 32'(t - tAct), 32'd2);

    $display("[TB] grants withheld");
    tick();
    gntEn = 1'b0;
    applyStimulus(1'b1, 14'h88, 10'h040, 4'd0, 1'b0, 4'd9);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("held_rd", {31'd0, bus.rd_req}, 32'd1);
      checkOutput("held_ca_id", {16'(bus.sched_ca), 16'(bus.sched_id)}, {16'h040, 16'd9});
      checkOutput("held_no_ready", {31'd0, bus.req_ready}, 32'd0);
      if (i < 4) tick();
    end
    gntEn = 1'b1;
    #1;
    checkOutput("held_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();

    $display("[TB] reset during ACTIVATING");
    tRcdM1 = 8'd5;
    applyStimulus(1'b1, 14'h99, 10'h000, 4'd0, 1'b0, 4'd10);
    waitFor("wait_act_99", 0, 40, t);
    tick();
    checkOutput("activating_open", {31'd0, rowOpen}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_reqs", anyReq(), 32'd0);
    checkOutput("async_rst_row", {31'd0, rowOpen}, 32'd0);
    checkOutput("async_rst_ra", 32'(bus.sched_ra), 32'd0);
    tick(); tick();
    checkOutput("in_rst_reqs", anyReq(), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_act", anyReq(), 32'b10000);
    checkOutput("post_rst_ra", 32'(bus.sched_ra), 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
